// File: rtl/memory_dumper.sv
// memory_dumper: streams a contiguous window of the 32x8 RAM to a host as (addr, data) words.
// Reads pass through a 2-stage in-flight pipe and land in a 4-entry FIFO guarded by a credit check.
module memory_dumper (
  input  logic       clock,
  input  logic       reset,
  input  logic       dump_start,
  input  logic [4:0] dump_base,
  input  logic [5:0] dump_count,
  input  logic [7:0] mem_read_data,
  output logic [4:0] mem_addr,
  output logic       mem_read_req,
  output logic [7:0] out_data,
  output logic [4:0] out_addr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       dump_busy,
  output logic       dump_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t     state, state_next;
  logic [5:0] issue_left;
  logic [4:0] next_addr;
  logic [4:0] mem_addr_q;

  // In-flight pipe: stage 1 holds the read issued on the last edge, stage 2 is captured next edge.
  logic       s1_valid, s2_valid;
  logic [4:0] s1_addr, s2_addr;

  logic [7:0] fifo_data [4];
  logic [4:0] fifo_addr [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] occ;

  logic [5:0] eff_count;
  logic [2:0] credit;
  logic       start_ok, issue, capture, pop;

  always_comb begin
    eff_count = (dump_count > 6'd32) ? 6'd32 : dump_count;
    credit    = occ + {2'b00, s1_valid} + {2'b00, s2_valid};
    start_ok  = (state == IDLE) && dump_start;
    // A pop in this cycle does not free a slot for issue; only settled occupancy counts.
    issue     = (state == READ) && (issue_left != 6'd0) && (credit < 3'd4);
    capture   = s2_valid;
    pop       = (occ != 3'd0) && out_ready;
  end

  // NOTE: state_next is given its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dump_start) state_next = (eff_count != 6'd0) ? READ : DONE;
      end
      READ: begin
        if ((issue_left == 6'd0) || (issue && (issue_left == 6'd1))) state_next = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid && ((occ == 3'd0) || ((occ == 3'd1) && pop)))
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_left <= '0;
      next_addr  <= '0;
      mem_addr_q <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_addr    <= '0;
      s2_addr    <= '0;
    end else begin
      if (start_ok && (eff_count != 6'd0)) begin
        issue_left <= eff_count;
        next_addr  <= dump_base;
      end else if (issue) begin
        issue_left <= issue_left - 6'd1;
        next_addr  <= next_addr + 5'd1;
        mem_addr_q <= next_addr;
      end
      s1_valid <= issue;
      if (issue) s1_addr <= next_addr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
    end
  end

  // NOTE: FIFO storage is reset too, so out_data/out_addr read 0 after reset instead of stale words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (capture) begin
        fifo_data[wr_ptr] <= mem_read_data;
        fifo_addr[wr_ptr] <= s2_addr;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      occ <= occ + {2'b00, capture} - {2'b00, pop};
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_read_req = (state != IDLE);
  assign dump_busy    = (state != IDLE);
  assign dump_done    = (state == DONE);
  assign out_valid    = (occ != 3'd0);
  assign out_data     = fifo_data[rd_ptr];
  assign out_addr     = fifo_addr[rd_ptr];

endmodule

// File: doc/memory_dumper.md
# memory_dumper

Read-back engine that streams a contiguous window of the unified 32x8 memory out to a host after execution, mirroring how `program_loader` fills it before execution. Sits beside the loader and CPU in the top level; while busy it requests ownership of the memory read port through the top-level address mux. Each word read is delivered with its address on a valid/ready stream. An internal 4-entry FIFO absorbs RAM latency and host backpressure.

## Interface
- No parameters; memory geometry is fixed at 32 words x 8 bits, 5-bit address.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- dump_start  in  1  one-cycle request to begin a dump; ignored while dump_busy=1.
- dump_base  in  5  first address to read; sampled on the dump_start edge.
- dump_count  in  6  number of words to read; sampled on the dump_start edge; 0 = none; values above 32 saturate to 32.
- mem_read_data  in  8  RAM data_out.
- mem_addr  out  5  registered read address to RAM.
- mem_read_req  out  1  high while busy; top level routes mem_addr to the RAM and forces RAM write_enable=0.
- out_data  out  8  FIFO head data.
- out_addr  out  5  address the head data was read from.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  host accepts the head word this cycle.
- dump_busy  out  1  state != IDLE.
- dump_done  out  1  one-cycle pulse when the last word has been accepted.

## Operation
- RAM contract: address sampled on edge N, data_out valid during the cycle after edge N, so a read is captured at edge N+1.
- A read is issued on an edge where mem_addr is loaded with a new address. It is in flight for 2 edges and is captured into the FIFO on the second edge.
- Counters:
  - issue_left (6 b): reads remaining to issue.
  - inflight (0..2): issued reads not yet captured.
  - occ (0..4): FIFO occupancy.
  - next_addr (5 b): next address to issue; increments mod 32, so 31 wraps to 0.
- Issue rule: issue when state=READ, issue_left>0 and occ+inflight<4. Same-cycle pops are not credited.
- Transfer: occurs when out_valid && out_ready; pops the FIFO head. Capture and pop in the same cycle leave occ unchanged.
- FSM:
  - IDLE: on dump_start with effective count>0, load issue_left and next_addr, then go to READ. With effective count 0, go to DONE.
  - READ: issue per rule. When issue_left reaches 0, go to DRAIN.
  - DRAIN: when inflight=0 and occ=0 (last word popped), go to DONE.
  - DONE: dump_done=1 for this cycle, then go to IDLE.
- dump_start asserted in any state other than IDLE has no effect.
- No write path exists; the block never modifies memory.

## Timing
- Reset (async, immediate): state=IDLE, FIFO emptied, counters 0.
  - Outputs: mem_addr=0, mem_read_req=0, out_valid=0, out_data=0, out_addr=0, dump_busy=0, dump_done=0.
  - Reset mid-dump discards everything in flight and in the FIFO.
- dump_start sampled at edge S:
  - dump_busy and mem_read_req go high after edge S.
  - First issue at edge S+1, with mem_addr=base after S+1.
  - First word captured at S+3, so out_valid first rises after edge S+3.
- With out_ready held high, one word transfers per cycle after the first. N words finish transferring in the cycle after edge S+2+N. dump_done is high in the cycle after the following edge, and IDLE follows on the next edge.
- Under backpressure, issuing stalls once occ+inflight=4. The FIFO never overflows and no word is lost or duplicated.
- out_data and out_addr stay stable while out_valid=1 and out_ready=0.
- Count 0: IDLE→DONE at S, dump_done pulses in the cycle after S, and out_valid never rises.
- mem_read_req stays high through READ, DRAIN and DONE.

## Test plan
- Basic dump: RAM preloaded with mem[i]=i+0x10, base=0, count=4, out_ready=1.
  - Stream is (0,0x10),(1,0x11),(2,0x12),(3,0x13).
  - First out_valid after S+3; dump_done pulses once; busy falls afterwards.
- Wrap-around: base=30, count=4.
  - out_addr sequence is 30,31,0,1 with matching data.
- Backpressure: count=8, out_ready toggles 1-cycle-on/2-off.
  - All 8 words arrive in order, no duplicates.
  - Head is stable while stalled.
  - occ+inflight never exceeds 4.
- Degenerate counts:
  - count=0: dump_done pulses in the cycle after S, no out_valid.
  - count=40: exactly 32 words, addresses base..base+31 mod 32.
- Start while busy: second dump_start during READ with different base/count.
  - Ignored; original stream completes unchanged.
- Reset mid-dump: assert reset after 2 of 6 words are transferred.
  - All outputs return to 0 immediately.
  - A following dump with base=5, count=2 yields (5,mem[5]),(6,mem[6]) only.
